dec2bin_fixed_entry: RTL and testbench
======================================

Name: dec2bin_fixed_entry

Overview:
- Keypad-side number entry for the calculator: the inverse of the binary-to-decimal display path.
- Accepts decimal key codes one per strobe (integer digits, decimal point, sign, clear, enter) and accumulates them into a signed fixed-point value.
- Commits the value as signed 8-bit integer part plus 0..99 hundredths fraction, the same format the display converter consumes.
- Sits between the keypad scanner/debouncer and the ALU operand registers.

Parameters:
- INT_MAX, 127, largest accepted integer magnitude (both signs); must be ≤127.
- FRAC_DIGITS, 2, maximum fraction digits accepted; fixed at 2 (hundredths).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- key_valid  input  1  one-cycle strobe: key_code valid this cycle
- key_code  input  4  0-9 digit, 4'hA point, 4'hB sign toggle, 4'hC clear, 4'hD enter, 4'hE backspace (feature-gated); 4'hF reserved
- acc_int  output  8  committed signed integer part, two's complement
- frac  output  7  committed hundredths magnitude 0..99
- neg  output  1  committed sign (needed for -0.xx, where acc_int=0)
- value_valid  output  1  one-cycle pulse the cycle after a valid enter
- busy  output  1  high while in S_INT or S_FRAC
- err  output  1  one-cycle pulse the cycle after a rejected key

Behaviour:
- Reset (async, rst=1): state S_IDLE. Working regs (mag, wfrac, wneg, fcnt) = 0. acc_int=0, frac=0, neg=0, value_valid=0, busy=0, err=0.
- Keys are sampled only on clk rising edge with key_valid=1. Registered outputs and new state appear the following cycle; at most one key per cycle.
- Working value: mag[6:0] 0..INT_MAX, wfrac 0..99, wneg, fcnt 0..2.
- S_IDLE:
  - Digit d: mag=d, wfrac=0, wneg=0, fcnt=0; go to S_INT.
  - Point: mag=0, wfrac=0, wneg=0, fcnt=0; go to S_FRAC.
  - Sign or enter: ignored, no err.
  - Clear: no effect.
- S_INT:
  - Digit d: if mag*10+d ≤ INT_MAX, mag updates; otherwise reject (err, mag unchanged). Leading zeros are accepted.
  - Point: go to S_FRAC.
- S_FRAC:
  - Digit d with fcnt=0: wfrac=d*10, fcnt=1.
  - Digit d with fcnt=1: wfrac=wfrac+d, fcnt=2.
  - Digit d with fcnt=2: reject (err).
  - Point: reject (err).
- S_INT/S_FRAC, any state-independent keys:
  - Sign: wneg toggles.
  - Clear: working regs to 0, go to S_IDLE. Committed outputs unchanged; no value_valid.
  - Enter: commit and go to S_IDLE.
- Commit:
  - neg = wneg & (mag≠0 | wfrac≠0); negative zero is forced to +0.
  - acc_int = neg ? -mag : mag; frac = wfrac; value_valid pulses.
- Consistency rule: the committed value equals acc_int*100 − frac when neg, acc_int*100 + frac otherwise.
- Key 4'hF is always ignored. Key 4'hE with the feature disabled is ignored. Neither raises err.
- busy = (state≠S_IDLE), registered.
- Committed outputs hold until the next commit or reset.
- rst asserted mid-entry aborts the entry immediately; all outputs return to reset values.

Optional Feature:
- Macro: DEC2BIN_BACKSPACE_EN.
- When defined, key 4'hE deletes the last entered character:
  - S_FRAC, fcnt=2: wfrac = (wfrac/10)*10, fcnt=1.
  - S_FRAC, fcnt=1: wfrac=0, fcnt=0.
  - S_FRAC, fcnt=0: go to S_INT (point removed).
  - S_INT, mag≥10: mag = mag/10.
  - S_INT, mag<10: working regs cleared, go to S_IDLE.
  - S_IDLE: ignored.
- A separate 1-bit flag records whether S_FRAC was entered directly from S_IDLE. If set, backspace at fcnt=0 returns to S_IDLE instead of S_INT.
- When not defined, 4'hE is ignored with no err, and no divide-by-10 logic is synthesized.

Test Plan:
- Keys 1,2,5,A,7,5,D → value_valid pulse once; acc_int=8'sd125, frac=75, neg=0; busy low after.
- Keys 4,2,B,A,5,D → acc_int=-42 (8'hD6), frac=50, neg=1.
- Keys A,3,B,D → acc_int=0, frac=30, neg=1. Then keys B,B,A,D → acc_int=0, frac=0, neg=0 (negative zero suppressed).
- Keys 1,2,8 → err pulse on 8, mag stays 12. Keys A,1,2,3 → err on 3 and on any second A. Enter → acc_int=12, frac=12.
- Keys 9,9,A,1 then C, then D → no value_valid, previous committed value unchanged, busy=0. Assert rst between two digits mid-entry → all outputs 0 asynchronously.
- With DEC2BIN_BACKSPACE_EN: keys 1,0,7,A,2,5,E,E,E,E,D → acc_int=10, frac=0. Without the macro, the same sequence yields acc_int=107, frac=25 and no err.

Source files
------------

// File: rtl/dec2bin_fixed_entry.sv
// dec2bin_fixed_entry
//   Keypad-side decimal number entry. Accumulates key codes into a signed
//   fixed-point value (integer magnitude 0..INT_MAX, hundredths 0..99) and
//   commits it on enter in the format used by the display converter.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   key_valid    one-cycle strobe, key_code valid this cycle
//   key_code     0-9 digit, A point, B sign, C clear, D enter, E backspace, F reserved
//   acc_int      committed signed integer part (two's complement)
//   frac         committed hundredths magnitude 0..99
//   neg          committed sign (distinguishes -0.xx)
//   value_valid  one-cycle pulse after an accepted enter
//   busy         high while an entry is in progress
//   err          one-cycle pulse after a rejected key
//
// Build option: define DEC2BIN_BACKSPACE_EN to enable key E as backspace;
// otherwise key E is ignored and no divide-by-10 logic is built.
module dec2bin_fixed_entry #(
    parameter int INT_MAX     = 127,
    parameter int FRAC_DIGITS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [7:0] acc_int,
    output logic [6:0] frac,
    output logic       neg,
    output logic       value_valid,
    output logic       busy,
    output logic       err
);

    typedef enum logic [1:0] {S_IDLE, S_INT, S_FRAC} state_t;

    localparam logic [3:0] KEY_POINT = 4'hA;
    localparam logic [3:0] KEY_SIGN  = 4'hB;
    localparam logic [3:0] KEY_CLEAR = 4'hC;
    localparam logic [3:0] KEY_ENTER = 4'hD;
`ifdef DEC2BIN_BACKSPACE_EN
    localparam logic [3:0] KEY_BACK  = 4'hE;
`endif

    state_t      state_q, state_d;
    logic [6:0]  mag_q, mag_d;
    logic [6:0]  wfrac_q, wfrac_d;
    logic        wneg_q, wneg_d;
    logic [1:0]  fcnt_q, fcnt_d;
    logic        from_idle_q, from_idle_d;   // S_FRAC was entered straight from S_IDLE
    logic [7:0]  acc_int_q, acc_int_d;
    logic [6:0]  frac_q, frac_d;
    logic        neg_q, neg_d;
    logic        value_valid_q, value_valid_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;

    logic        is_digit;
    logic [10:0] mag_next;
    logic        commit_neg;

    assign is_digit   = (key_code <= 4'd9);
    assign mag_next   = ({4'b0, mag_q} * 11'd10) + {7'b0, key_code};
    // Negative zero collapses to +0 on commit
    assign commit_neg = wneg_q & ((mag_q != '0) | (wfrac_q != '0));

    always_comb begin
        state_d       = state_q;
        mag_d         = mag_q;
        wfrac_d       = wfrac_q;
        wneg_d        = wneg_q;
        fcnt_d        = fcnt_q;
        from_idle_d   = from_idle_q;
        acc_int_d     = acc_int_q;
        frac_d        = frac_q;
        neg_d         = neg_q;
        value_valid_d = 1'b0;
        err_d         = 1'b0;

        if (key_valid) begin
            if (state_q == S_IDLE) begin
                if (is_digit) begin
                    mag_d   = {3'b0, key_code};
                    wfrac_d = '0;
                    wneg_d  = 1'b0;
                    fcnt_d  = '0;
                    state_d = S_INT;
                end else if (key_code == KEY_POINT) begin
                    mag_d       = '0;
                    wfrac_d     = '0;
                    wneg_d      = 1'b0;
                    fcnt_d      = '0;
                    from_idle_d = 1'b1;
                    state_d     = S_FRAC;
                end
            end else if (is_digit) begin
                if (state_q == S_INT) begin
                    if (mag_next <= 11'(INT_MAX))
                        mag_d = mag_next[6:0];
                    else
                        err_d = 1'b1;
                end else if (fcnt_q >= 2'(FRAC_DIGITS)) begin
                    err_d = 1'b1;
                end else if (fcnt_q == 2'd0) begin
                    wfrac_d = {3'b0, key_code} * 7'd10;
                    fcnt_d  = 2'd1;
                end else begin
                    wfrac_d = wfrac_q + {3'b0, key_code};
                    fcnt_d  = 2'd2;
                end
            end else begin
                case (key_code)
                    KEY_POINT: begin
                        if (state_q == S_INT) begin
                            state_d     = S_FRAC;
                            from_idle_d = 1'b0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    KEY_SIGN: wneg_d = ~wneg_q;
                    KEY_CLEAR: begin
                        mag_d   = '0;
                        wfrac_d = '0;
                        wneg_d  = 1'b0;
                        fcnt_d  = '0;
                        state_d = S_IDLE;
                    end
                    KEY_ENTER: begin
                        neg_d         = commit_neg;
                        acc_int_d     = commit_neg ? (8'd0 - {1'b0, mag_q}) : {1'b0, mag_q};
                        frac_d        = wfrac_q;
                        value_valid_d = 1'b1;
                        mag_d         = '0;
                        wfrac_d       = '0;
                        wneg_d        = 1'b0;
                        fcnt_d        = '0;
                        state_d       = S_IDLE;
                    end
`ifdef DEC2BIN_BACKSPACE_EN
                    KEY_BACK: begin
                        if (state_q == S_FRAC) begin
                            if (fcnt_q == 2'd2) begin
                                wfrac_d = (wfrac_q / 7'd10) * 7'd10;
                                fcnt_d  = 2'd1;
                            end else if (fcnt_q == 2'd1) begin
                                wfrac_d = '0;
                                fcnt_d  = '0;
                            end else if (from_idle_q) begin
                                mag_d   = '0;
                                wfrac_d = '0;
                                wneg_d  = 1'b0;
                                state_d = S_IDLE;
                            end else begin
                                state_d = S_INT;
                            end
                        end else if (mag_q >= 7'd10) begin
                            mag_d = mag_q / 7'd10;
                        end else begin
                            mag_d   = '0;
                            wfrac_d = '0;
                            wneg_d  = 1'b0;
                            fcnt_d  = '0;
                            state_d = S_IDLE;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            mag_q         <= '0;
            wfrac_q       <= '0;
            wneg_q        <= 1'b0;
            fcnt_q        <= '0;
            from_idle_q   <= 1'b0;
            acc_int_q     <= '0;
            frac_q        <= '0;
            neg_q         <= 1'b0;
            value_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            mag_q         <= mag_d;
            wfrac_q       <= wfrac_d;
            wneg_q        <= wneg_d;
            fcnt_q        <= fcnt_d;
            from_idle_q   <= from_idle_d;
            acc_int_q     <= acc_int_d;
            frac_q        <= frac_d;
            neg_q         <= neg_d;
            value_valid_q <= value_valid_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
        end
    end

    assign acc_int     = acc_int_q;
    assign frac        = frac_q;
    assign neg         = neg_q;
    assign value_valid = value_valid_q;
    assign busy        = busy_q;
    assign err         = err_q;

endmodule

// File: tb/tb_dec2bin_fixed_entry.sv
// Testbench for dec2bin_fixed_entry: directed key sequences, expected commits
// queued on enter and compared when value_valid pulses.
module tb_dec2bin_fixed_entry;

    logic       clk;
    logic       rst;
    logic       key_valid;
    logic [3:0] key_code;
    logic [7:0] acc_int;
    logic [6:0] frac;
    logic       neg;
    logic       value_valid;
    logic       busy;
    logic       err;

    typedef struct {
        logic [7:0] a;
        logic [6:0] f;
        logic       n;
    } exp_t;

    exp_t sb[$];
    exp_t held;
    int   vectors;
    int   miscompares;

    dec2bin_fixed_entry dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .acc_int     (acc_int),
        .frac        (frac),
        .neg         (neg),
        .value_valid (value_valid),
        .busy        (busy),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_held();
        chk("acc_int_held", 32'(acc_int), 32'(held.a));
        chk("frac_held", 32'(frac), 32'(held.f));
        chk("neg_held", 32'(neg), 32'(held.n));
    endtask

    // Drive one key strobe, then check err and any commit the cycle after
    task automatic key(input logic [3:0] k, input logic e_err);
        exp_t e;
        key_valid = 1'b1;
        key_code  = k;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        chk("err", 32'(err), 32'(e_err));
        if (sb.size() > 0) begin
            chk("value_valid", 32'(value_valid), 32'd1);
            e    = sb.pop_front();
            held = e;
            chk("acc_int", 32'(acc_int), 32'(e.a));
            chk("frac", 32'(frac), 32'(e.f));
            chk("neg", 32'(neg), 32'(e.n));
        end else begin
            chk("value_valid", 32'(value_valid), 32'd0);
        end
    endtask

    task automatic enter(input logic [7:0] a, input logic [6:0] f, input logic n);
        exp_t e;
        e.a = a;
        e.f = f;
        e.n = n;
        sb.push_back(e);
        key(4'hD, 1'b0);
    endtask

    // One idle cycle: pulses must have dropped
    task automatic idle_cycle();
        @(posedge clk);
        #1;
        chk("vv_drop", 32'(value_valid), 32'd0);
        chk("err_drop", 32'(err), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        held.a = '0;
        held.f = '0;
        held.n = 1'b0;
        rst       = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        #12;
        chk("rst_acc_int", 32'(acc_int), 32'd0);
        chk("rst_frac", 32'(frac), 32'd0);
        chk("rst_neg", 32'(neg), 32'd0);
        chk("rst_vv", 32'(value_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 125.75
        key(4'h1, 1'b0);
        chk("busy_int", 32'(busy), 32'd1);
        key(4'h2, 1'b0);
        key(4'h5, 1'b0);
        key(4'hA, 1'b0);
        key(4'h7, 1'b0);
        key(4'h5, 1'b0);
        enter(8'd125, 7'd75, 1'b0);
        chk("busy_after_enter", 32'(busy), 32'd0);
        idle_cycle();

        // -42.50
        key(4'h4, 1'b0);
        key(4'h2, 1'b0);
        key(4'hB, 1'b0);
        key(4'hA, 1'b0);
        key(4'h5, 1'b0);
        enter(8'hD6, 7'd50, 1'b1);

        // -0.30, then negative zero forced positive
        key(4'hA, 1'b0);
        chk("busy_frac", 32'(busy), 32'd1);
        key(4'h3, 1'b0);
        key(4'hB, 1'b0);
        enter(8'd0, 7'd30, 1'b1);
        key(4'hA, 1'b0);
        key(4'hB, 1'b0);
        enter(8'd0, 7'd0, 1'b0);
        key(4'hB, 1'b0);   // sign in idle: ignored
        key(4'hB, 1'b0);
        key(4'hD, 1'b0);   // enter in idle: ignored, no commit
        check_held();
        key(4'hA, 1'b0);
        enter(8'd0, 7'd0, 1'b0);

        // Overflow and fraction rejects
        key(4'h1, 1'b0);
        key(4'h2, 1'b0);
        key(4'h8, 1'b1);
        key(4'hA, 1'b0);
        key(4'h1, 1'b0);
        key(4'h2, 1'b0);
        key(4'h3, 1'b1);
        key(4'hA, 1'b1);
        key(4'hF, 1'b0);   // reserved: ignored
        enter(8'd12, 7'd12, 1'b0);

        // Boundary: -127 and leading zeros
        key(4'h1, 1'b0);
        key(4'h2, 1'b0);
        key(4'h7, 1'b0);
        key(4'hB, 1'b0);
        enter(8'h81, 7'd0, 1'b1);
        key(4'h0, 1'b0);
        key(4'h0, 1'b0);
        key(4'h9, 1'b0);
        enter(8'd9, 7'd0, 1'b0);

        // Clear aborts entry with no commit
        key(4'h9, 1'b0);
        key(4'h9, 1'b0);
        key(4'hA, 1'b0);
        key(4'h1, 1'b0);
        key(4'hC, 1'b0);
        chk("busy_after_clear", 32'(busy), 32'd0);
        key(4'hD, 1'b0);
        check_held();
        chk("busy_idle", 32'(busy), 32'd0);

        // Backspace sequence
        key(4'h1, 1'b0);
        key(4'h0, 1'b0);
        key(4'h7, 1'b0);
        key(4'hA, 1'b0);
        key(4'h2, 1'b0);
        key(4'h5, 1'b0);
        key(4'hE, 1'b0);
        key(4'hE, 1'b0);
        key(4'hE, 1'b0);
        key(4'hE, 1'b0);
`ifdef DEC2BIN_BACKSPACE_EN
        enter(8'd10, 7'd0, 1'b0);
`else
        enter(8'd107, 7'd25, 1'b0);
`endif

        // Point from idle, then backspace back out
        key(4'hA, 1'b0);
        key(4'h5, 1'b0);
        key(4'hE, 1'b0);
        key(4'hE, 1'b0);
`ifdef DEC2BIN_BACKSPACE_EN
        chk("busy_bs_idle", 32'(busy), 32'd0);
`else
        chk("busy_bs_idle", 32'(busy), 32'd1);
`endif
        key(4'hC, 1'b0);

        // Async reset mid-entry
        key(4'h5, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_acc_int", 32'(acc_int), 32'd0);
        chk("arst_frac", 32'(frac), 32'd0);
        chk("arst_neg", 32'(neg), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_vv", 32'(value_valid), 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        key(4'h6, 1'b0);
        enter(8'd6, 7'd0, 1'b0);
        idle_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
